// File: rtl/busarb_rr.sv
// busarb_rr: round-robin bus arbiter for NUM_MASTERS masters, parking on the last owner.
// Define BUSARB_TIMEOUT_EN to preempt a contended owner after MAX_HOLD cycles of tenure.
module busarb_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int IDW = $clog2(NUM_MASTERS),
    parameter int MAX_HOLD = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] breq_,
    output logic [NUM_MASTERS-1:0] bgrt_,
    output logic [IDW-1:0]         bgrt_id
);
    if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_n
        $error("busarb_rr: NUM_MASTERS must be 2..16");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_hold
        $error("busarb_rr: MAX_HOLD must be 2..65535");
    end
    logic [NUM_MASTERS-1:0] req;
    logic [IDW-1:0]         owner, rr_next, owner_next;
    logic                   found, preempt;
    assign req = ~breq_;
    // Search owner+1, owner+2, ... modulo NUM_MASTERS for the next requester.
    always_comb begin
        logic [IDW-1:0] idx;
        idx = '0;
        rr_next = owner;
        found = 1'b0;
        for (int k = 1; k < NUM_MASTERS; k++) begin
            idx = IDW'((int'(owner) + k) % NUM_MASTERS);
            if (!found && req[idx]) begin
                rr_next = idx;
                found = 1'b1;
            end
        end
    end
`ifdef BUSARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD);
    logic [CW-1:0] cnt;
    assign preempt = (cnt == CW'(MAX_HOLD - 1)) && req[owner] && found;
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (owner_next != owner) cnt <= '0;
        else if (cnt != CW'(MAX_HOLD - 1)) cnt <= cnt + CW'(1);
    end
`else
    assign preempt = 1'b0;
`endif
    assign owner_next = (found && (!req[owner] || preempt)) ? rr_next : owner;
    always_ff @(posedge clk) begin
        if (reset) owner <= '0;
        else owner <= owner_next;
    end
    assign bgrt_   = ~(NUM_MASTERS'(1) << owner);
    assign bgrt_id = owner;
endmodule

// File: tb/tb_busarb_rr.sv
// tb_busarb_rr: directed and randomized checks of busarb_rr against a rule-level reference model.
module tb_busarb_rr;
    localparam int N = 4;
    localparam int MAXH = 4;
`ifdef BUSARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] breq_ = '0;
    logic [N-1:0] bgrt_;
    logic [1:0]   bgrt_id;
    int checks = 0;
    int errors = 0;
    int m_owner = 0;
    int m_cnt = 0;

    busarb_rr #(.NUM_MASTERS(N), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .reset(reset), .breq_(breq_), .bgrt_(bgrt_), .bgrt_id(bgrt_id)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] gnt(input int o);
        logic [N-1:0] g;
        g = '1;
        g[o] = 1'b0;
        return g;
    endfunction

    // One clock edge; the model applies the arbitration rules to the inputs sampled at that edge.
    task automatic tick();
        logic [N-1:0] r;
        int nxt;
        bit due;
        r = ~breq_;
        nxt = -1;
        @(posedge clk);
        if (reset) begin
            m_owner = 0;
            m_cnt = 0;
        end else begin
            for (int k = 1; k < N; k++)
                if (nxt < 0 && r[(m_owner + k) % N]) nxt = (m_owner + k) % N;
            due = TMO && m_cnt == MAXH - 1 && r[m_owner] && nxt >= 0;
            if (nxt >= 0 && (!r[m_owner] || due)) begin
                m_owner = nxt;
                m_cnt = 0;
            end else if (m_cnt < MAXH - 1) m_cnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        breq_ = 4'b0000;
        tick();
        tick();
        checks++;
        if (bgrt_ !== 4'b1110 || bgrt_id !== 2'd0) begin
            errors++;
            $display("FAIL reset: bgrt_=%b id=%0d want 1110 id=0", bgrt_, bgrt_id);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bgrt_ !== 4'b1110) begin
            errors++;
            $display("FAIL reset_hold: bgrt_=%b want 1110", bgrt_);
        end
    endtask

    task automatic test_parking();
        int bad = 0;
        breq_ = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bgrt_ !== 4'b1110) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL parking: %0d cycles off 1110, last bgrt_=%b", bad, bgrt_);
        end
        breq_ = 4'b1101;
        tick();
        checks++;
        if (bgrt_ !== 4'b1101 || bgrt_id !== 2'd1) begin
            errors++;
            $display("FAIL park_handover: bgrt_=%b id=%0d want 1101 id=1", bgrt_, bgrt_id);
        end
    endtask

    task automatic test_rotation();
        breq_ = 4'b0101;
        tick();
        checks++;
        if (bgrt_ !== 4'b1101) begin
            errors++;
            $display("FAIL rot_hold: bgrt_=%b want 1101", bgrt_);
        end
        breq_ = 4'b0111;
        tick();
        checks++;
        if (bgrt_ !== 4'b0111 || bgrt_id !== 2'd3) begin
            errors++;
            $display("FAIL rot_to3: bgrt_=%b id=%0d want 0111 id=3", bgrt_, bgrt_id);
        end
        breq_ = 4'b1110;
        tick();
        checks++;
        if (bgrt_ !== 4'b1110 || bgrt_id !== 2'd0) begin
            errors++;
            $display("FAIL rot_wrap: bgrt_=%b id=%0d want 1110 id=0", bgrt_, bgrt_id);
        end
    endtask

    task automatic test_no_preempt();
        int bad = 0;
        breq_ = 4'b1011;
        tick();
        checks++;
        if (bgrt_ !== 4'b1011) begin
            errors++;
            $display("FAIL np_grant2: bgrt_=%b want 1011", bgrt_);
        end
        breq_ = 4'b0000;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bgrt_ !== gnt(m_owner) || (!TMO && bgrt_ !== 4'b1011)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL np_hold: %0d bad cycles, last bgrt_=%b model=%b", bad, bgrt_, gnt(m_owner));
        end
        breq_ = 4'b0100;
        tick();
        checks++;
        if (bgrt_ !== gnt(m_owner) || (!TMO && bgrt_id !== 2'd3)) begin
            errors++;
            $display("FAIL np_release: bgrt_=%b id=%0d model=%b", bgrt_, bgrt_id, gnt(m_owner));
        end
    endtask

`ifdef BUSARB_TIMEOUT_EN
    task automatic test_timeout();
        int n = 1;
        int bad = 0;
        breq_ = 4'b1101;
        tick();
        breq_ = 4'b1001;
        while (bgrt_ === 4'b1101 && n < 20) begin
            tick();
            if (bgrt_ === 4'b1101) n++;
        end
        checks++;
        if (n != MAXH || bgrt_ !== 4'b1011) begin
            errors++;
            $display("FAIL timeout: held %0d cycles then bgrt_=%b, want %0d then 1011", n, bgrt_, MAXH);
        end
        breq_ = 4'b1101;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bgrt_ !== 4'b1101) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_uncontended: %0d cycles off 1101", bad);
        end
    endtask
`endif

    task automatic test_reset_mid();
        breq_ = 4'b0111;
        tick();
        tick();
        tick();
        checks++;
        if (bgrt_ !== 4'b0111) begin
            errors++;
            $display("FAIL mid_setup: bgrt_=%b want 0111", bgrt_);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bgrt_ !== 4'b1110 || bgrt_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: bgrt_=%b id=%0d want 1110 id=0", bgrt_, bgrt_id);
        end
        tick();
        checks++;
        if (bgrt_ !== 4'b0111 || bgrt_id !== 2'd3) begin
            errors++;
            $display("FAIL mid_after: bgrt_=%b id=%0d want 0111 id=3", bgrt_, bgrt_id);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            breq_ = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            tick();
            checks++;
            if (bgrt_ !== gnt(m_owner) || bgrt_id !== 2'(m_owner) || $countones(~bgrt_) != 1) begin
                errors++;
                $display("FAIL random[%0d]: bgrt_=%b id=%0d want %b id=%0d", i, bgrt_, bgrt_id, gnt(m_owner), m_owner);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_parking();
        test_rotation();
        test_no_preempt();
`ifdef BUSARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/busarb_rr.md
Name: busarb_rr

Overview:
- Parametrised round-robin bus arbiter for NUM_MASTERS bus masters sharing one system bus.
- Generalises the fixed two-master arbiter: any master count, fair round-robin rotation, parking on the last owner, and optional tenure-limit preemption.
- Sits between the masters' active-low request lines and the bus mux select.
- Always grants exactly one master.

Parameters:
- NUM_MASTERS, 4, number of requesting masters; legal range 2..16; elaboration error otherwise.
- IDW, $clog2(NUM_MASTERS), width of the encoded owner index; derived, not overridden.
- MAX_HOLD, 16, tenure limit in cycles; used only with BUSARB_TIMEOUT_EN; legal 2..65535.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous reset, active-high.
- breq_  input  NUM_MASTERS  per-master bus request, active-low; bit i = master i.
- bgrt_  output  NUM_MASTERS  per-master bus grant, active-low; exactly one bit low at all times.
- bgrt_id  output  IDW  binary index of the current owner; drives the bus mux select.

Behaviour:
- Interface (decided): one clock, clk; reset is synchronous and active-high, port reset.
- State: owner register, IDW bits.
  - bgrt_ = ~(1 << owner); bgrt_id = owner.
  - Both outputs are purely combinational from registers; no input-to-output combinational path.
- Reset: at a posedge with reset=1:
  - owner <= 0, tenure counter <= 0.
  - Outputs after that edge: bgrt_ = all ones except bit 0 low; bgrt_id = 0.
  - Reset has priority over every other event, including mid-tenure; no request history is retained.
- Per-edge decision (reset=0), evaluated in order:
  - 1. If owner's breq_ is low (owner still requesting) and no preemption is due: hold owner.
  - 2. Else, if any other master's breq_ is low: owner <= first requesting master found searching owner+1, owner+2, ... modulo NUM_MASTERS, skipping owner itself.
  - 3. Else (no requests, or only the owner releasing with nobody waiting): hold owner (parking).
- Latency:
  - A parked-on master sees its grant with zero wait.
  - A non-owner requester is granted on the first edge where the owner's breq_ is sampled high (or preemption fires). Its bgrt_ goes low in the cycle after that edge.
  - Handover is atomic: no cycle with zero grants, no cycle with two.
- Round-robin fairness: with all masters continuously requesting and each releasing after its tenure, service order is strictly cyclic. No master waits more than NUM_MASTERS-1 tenures.
- No preemption without the optional feature: an owner holding breq_ low keeps the bus indefinitely.
- breq_ bits are sampled only at posedge. Glitches between edges have no effect.
- Masters are responsible for synchronising breq_ to clk.

Optional Feature:
- Macro: BUSARB_TIMEOUT_EN.
- Defined: adds a tenure counter of $clog2(MAX_HOLD) bits.
  - Cleared on reset and on every owner change.
  - Otherwise increments each cycle, saturating at MAX_HOLD-1.
  - Preemption is due when counter == MAX_HOLD-1, owner still requesting, and at least one other master requesting. Owner then moves per rule 2 at that edge.
  - Net effect: a contended owner keeps the grant for exactly MAX_HOLD cycles. An uncontended owner is never preempted.
  - A preempted master re-enters rotation normally.
- Undefined: no counter logic; MAX_HOLD ignored; port list identical.

Test Plan:
- 1. Reset: NUM_MASTERS=4, reset=1 for 2 edges, breq_=4'b0000 -> after edge bgrt_=4'b1110, bgrt_id=0; holds at least 1 cycle after reset drops, since master 0 is requesting.
- 2. Parking: after reset, breq_=4'b1111 for 20 cycles -> bgrt_ stays 4'b1110. Then breq_=4'b1101 -> bgrt_=4'b1101, bgrt_id=1 one cycle after the sampling edge.
- 3. Rotation/wrap: owner=1 requesting, breq_=4'b0101 (masters 1,3). Master 1 releases, breq_=4'b0111 -> owner 3, bgrt_=4'b0111. Then breq_=4'b1110 -> owner wraps to 0, bgrt_=4'b1110.
- 4. No preemption (macro off): owner 2, breq_=4'b0000 for 100 cycles -> bgrt_ stays 4'b1011; on release the next owner is 3.
- 5. Timeout (macro on, MAX_HOLD=4): master 1 granted at cycle T, breq_=4'b1001 throughout -> bgrt_=4'b1101 for exactly 4 cycles, then 4'b1011. Repeat with breq_=4'b1101 -> no preemption for 50 cycles.
- 6. Reset mid-operation: owner 3 with counter at 2, assert reset one edge -> bgrt_=4'b1110, counter=0. With breq_=4'b0111 after reset, owner moves to 3 on the next edge, since master 0 is not requesting.
